// File: rtl/dmem_copy_engine_if.sv
// Control and dual-port memory bundle between the CPU control path, the copy
// engine and the data memory.
interface dmem_copy_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [ADDR_WIDTH:0]   len;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic                  rd_en1;
   logic                  rd_en2;
   logic [ADDR_WIDTH-1:0] rd_addr1;
   logic [ADDR_WIDTH-1:0] rd_addr2;
   logic [DATA_WIDTH-1:0] data_out1;
   logic [DATA_WIDTH-1:0] data_out2;
   logic                  wr_en1;
   logic                  wr_en2;
   logic [ADDR_WIDTH-1:0] wr_addr1;
   logic [ADDR_WIDTH-1:0] wr_addr2;
   logic [DATA_WIDTH-1:0] data_in1;
   logic [DATA_WIDTH-1:0] data_in2;

   modport master (
      input  start, src_addr, dst_addr, len, data_out1, data_out2,
      output busy, done, error, rd_en1, rd_en2, rd_addr1, rd_addr2,
             wr_en1, wr_en2, wr_addr1, wr_addr2, data_in1, data_in2
   );

   modport slave (
      output start, src_addr, dst_addr, len, data_out1, data_out2,
      input  busy, done, error, rd_en1, rd_en2, rd_addr1, rd_addr2,
             wr_en1, wr_en2, wr_addr1, wr_addr2, data_in1, data_in2
   );
endinterface

// File: rtl/dmem_copy_engine.sv
// Block-copy engine for the dual-port data memory: reads two words per cycle
// from a source region and writes them one cycle later to a destination region.
module dmem_copy_engine #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rstn,
   dmem_copy_engine_if.master bus
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam int EW = ADDR_WIDTH + 2;
   localparam logic [EW-1:0] LP_DEPTH = EW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_accept;
   logic                  w_issue;
   logic [EW-1:0]         w_src_end;
   logic [EW-1:0]         w_dst_end;
   logic                  w_len_zero;
   logic                  w_bad;
   logic                  w_two;
   logic [DATA_WIDTH-1:0] w_data1;
   logic [DATA_WIDTH-1:0] w_data2;

   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_wr_base;
   logic [CW-1:0]         r_remaining;
   logic                  r_rd_en1;
   logic                  r_rd_en2;
   logic [ADDR_WIDTH-1:0] r_rd_addr1;
   logic [ADDR_WIDTH-1:0] r_rd_addr2;
   logic [ADDR_WIDTH-1:0] r_pend_base_p1;
   logic                  r_wr_en1;
   logic                  r_wr_en2;
   logic [ADDR_WIDTH-1:0] r_wr_addr1;
   logic [ADDR_WIDTH-1:0] r_wr_addr2;

   // Range ends are computed two bits wider so a wrapping command is visible.
   assign w_src_end  = {2'b00, bus.src_addr} + {1'b0, bus.len};
   assign w_dst_end  = {2'b00, bus.dst_addr} + {1'b0, bus.len};
   assign w_len_zero = (bus.len == '0);
   assign w_bad      = (w_src_end > LP_DEPTH) || (w_dst_end > LP_DEPTH) ||
                       (({2'b00, bus.src_addr} < w_dst_end) &&
                        ({2'b00, bus.dst_addr} < w_src_end));
   assign w_two      = (r_remaining >= CW'(2));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (w_len_zero || w_bad) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_COPY;
                  w_accept     = 1'b1;
               end
            end
         end
         S_COPY: begin
            w_issue = 1'b1;
            if (r_remaining <= CW'(2)) w_next_state = S_DRAIN;
         end
         S_DRAIN: w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_rd_ptr       <= '0;
         r_wr_base      <= '0;
         r_remaining    <= '0;
         r_rd_en1       <= 1'b0;
         r_rd_en2       <= 1'b0;
         r_rd_addr1     <= '0;
         r_rd_addr2     <= '0;
         r_pend_base_p1 <= '0;
         r_wr_en1       <= 1'b0;
         r_wr_en2       <= 1'b0;
         r_wr_addr1     <= '0;
         r_wr_addr2     <= '0;
      end else begin
         r_busy <= (w_next_state == S_COPY) || (w_next_state == S_DRAIN);
         r_done <= (w_next_state == S_DONE);
         if ((r_state == S_IDLE) && bus.start) r_error <= !w_len_zero && w_bad;
         if (w_accept) begin
            r_rd_ptr    <= bus.src_addr;
            r_wr_base   <= bus.dst_addr;
            r_remaining <= bus.len;
         end
         // Read beat: port 2 only while at least two words remain.
         r_rd_en1 <= w_issue;
         r_rd_en2 <= w_issue && w_two;
         if (w_issue) begin
            r_rd_addr1     <= r_rd_ptr;
            r_rd_addr2     <= r_rd_ptr + ADDR_WIDTH'(1);
            r_rd_ptr       <= r_rd_ptr + ADDR_WIDTH'(2);
            r_remaining    <= w_two ? (r_remaining - CW'(2)) : '0;
            r_pend_base_p1 <= r_wr_base;
            r_wr_base      <= r_wr_base + ADDR_WIDTH'(2);
         end
         // Write beat: follows its read beat by one cycle, when the memory data lands.
         r_wr_en1 <= r_rd_en1;
         r_wr_en2 <= r_rd_en2;
         if (r_rd_en1) begin
            r_wr_addr1 <= r_pend_base_p1;
            r_wr_addr2 <= r_pend_base_p1 + ADDR_WIDTH'(1);
         end
      end
   end

   assign w_data1       = bus.data_out1;
   assign w_data2       = bus.data_out2;
   assign bus.data_in1  = w_data1;
   assign bus.data_in2  = w_data2;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.error     = r_error;
   assign bus.rd_en1    = r_rd_en1;
   assign bus.rd_en2    = r_rd_en2;
   assign bus.rd_addr1  = r_rd_addr1;
   assign bus.rd_addr2  = r_rd_addr2;
   assign bus.wr_en1    = r_wr_en1;
   assign bus.wr_en2    = r_wr_en2;
   assign bus.wr_addr1  = r_wr_addr1;
   assign bus.wr_addr2  = r_wr_addr2;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: dual-port registered-read memory model, shadow
// memory and a queue of expected write beats.
module tb_dmem_copy_engine;
   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       ld_en;
   logic [2:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] mem     [8];
   logic [7:0] exp_mem [8];
   wr_t        sb_q[$];
   int         total = 0;
   int         bad   = 0;

   dmem_copy_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   dmem_copy_engine #(.DEPTH(8), .DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Data memory: 1-cycle registered reads, writes on the rising edge.
   always @(posedge clk) begin
      if (bus.rd_en1) bus.data_out1 <= mem[bus.rd_addr1];
      if (bus.rd_en2) bus.data_out2 <= mem[bus.rd_addr2];
      if (bus.wr_en1) mem[bus.wr_addr1] <= bus.data_in1;
      if (bus.wr_en2) mem[bus.wr_addr2] <= bus.data_in2;
      if (ld_en)      mem[ld_addr]      <= ld_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_word(input int a, input logic [7:0] d);
      ld_en      = 1'b1;
      ld_addr    = 3'(a);
      ld_data    = d;
      exp_mem[a] = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 8; i++) chk({tag, "_mem"}, 32'(mem[i]), 32'(exp_mem[i]));
   endtask

   task automatic pop_write(input string tag, input logic [2:0] a, input logic [7:0] d);
      wr_t e;
      chk({tag, "_wr_expected"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_wr_addr_data"}, 32'({a, d}), 32'({e.a, e.d}));
      end
   endtask

   // Issues one command from a negedge and follows it to completion.
   task automatic do_copy(input string tag, input int src, input int dst, input int len,
                          input bit exp_err, input int lat, input bit again);
      wr_t e;
      int  n1;
      int  n2;
      int  k;
      bit  got_done;
      bit  valid;
      valid = !exp_err && (len > 0);
      if (valid) begin
         for (int i = 0; i < len; i++) begin
            e.a = 3'(dst + i);
            e.d = exp_mem[src + i];
            sb_q.push_back(e);
         end
         for (int i = 0; i < len; i++) exp_mem[dst + i] = exp_mem[src + i];
      end
      bus.src_addr = 3'(src);
      bus.dst_addr = 3'(dst);
      bus.len      = 4'(len);
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      n1 = 0;
      n2 = 0;
      k  = 1;
      got_done = 1'b0;
      while (!got_done && k <= 12) begin
         if (again && k == 1) begin
            bus.start    = 1'b1;
            bus.src_addr = 3'd5;
            bus.dst_addr = 3'd1;
            bus.len      = 4'd1;
         end
         if (again && k == 2) bus.start = 1'b0;
         if (bus.rd_en1) n1++;
         if (bus.rd_en2) n2++;
         if (bus.wr_en1) pop_write(tag, bus.wr_addr1, bus.data_in1);
         if (bus.wr_en2) pop_write(tag, bus.wr_addr2, bus.data_in2);
         chk({tag, "_busy"}, 32'(bus.busy), 32'(k < lat));
         if (bus.done) begin
            got_done = 1'b1;
            chk({tag, "_latency"}, 32'(k), 32'(lat));
            chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
         end
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_rd1_beats"}, 32'(n1), valid ? 32'((len + 1) / 2) : 32'd0);
      chk({tag, "_rd2_beats"}, 32'(n2), valid ? 32'(len / 2) : 32'd0);
      chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      check_mem(tag);
   endtask

   initial begin
      rstn         = 1'b0;
      ld_en        = 1'b0;
      ld_addr      = '0;
      ld_data      = '0;
      bus.start    = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.len      = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 32'({bus.busy, bus.done, bus.error}), 32'd0);
      chk("rst_rd_en", 32'({bus.rd_en1, bus.rd_en2}), 32'd0);
      chk("rst_wr_en", 32'({bus.wr_en1, bus.wr_en2}), 32'd0);
      chk("rst_addr", 32'({bus.rd_addr1, bus.rd_addr2, bus.wr_addr1, bus.wr_addr2}), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      load_word(0, 8'd11);
      load_word(1, 8'd22);
      load_word(2, 8'd33);
      load_word(3, 8'd44);
      load_word(4, 8'h55);
      load_word(5, 8'h66);
      load_word(6, 8'h77);
      load_word(7, 8'h88);
      do_copy("even4", 0, 4, 4, 1'b0, 4, 1'b0);

      load_word(5, 8'hEE);
      load_word(6, 8'hEE);
      load_word(7, 8'hEE);
      do_copy("odd3", 1, 5, 3, 1'b0, 4, 1'b0);

      do_copy("len0", 2, 3, 0, 1'b0, 1, 1'b0);
      do_copy("overlap", 0, 2, 4, 1'b1, 1, 1'b0);
      do_copy("range", 6, 0, 3, 1'b1, 1, 1'b0);
      @(negedge clk);
      chk("error_held", 32'(bus.error), 32'd1);
      do_copy("clear_err", 6, 0, 2, 1'b0, 3, 1'b0);
      do_copy("restart_ignored", 0, 4, 4, 1'b0, 4, 1'b1);

      // Abort a copy after its first read beat, before any write is issued.
      load_word(0, 8'h5A);
      load_word(1, 8'hA5);
      bus.src_addr = 3'd0;
      bus.dst_addr = 3'd4;
      bus.len      = 4'd4;
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("mid_rd_en", 32'(bus.rd_en1), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("abort_ctrl", 32'({bus.busy, bus.done, bus.error}), 32'd0);
      chk("abort_en", 32'({bus.rd_en1, bus.rd_en2, bus.wr_en1, bus.wr_en2}), 32'd0);
      chk("abort_addr", 32'({bus.rd_addr1, bus.rd_addr2, bus.wr_addr1, bus.wr_addr2}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'({bus.busy, bus.done}), 32'd0);
      check_mem("abort");
      do_copy("after_rst", 0, 6, 2, 1'b0, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
